// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential step, branches, exceptions and a
// circular return-address stack for call/return prediction.
module pc_gen #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       STEP         = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h0000_0020),
  parameter int unsigned       RAS_DEPTH    = 4,
  localparam int unsigned      CNT_W        = $clog2(RAS_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              exc_flag,
  input  logic              branch_flag,
  input  logic              link_flag,
  input  logic              ret_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic [ADDR_W-1:0] epc,
  output logic              addr_err,
  output logic [CNT_W-1:0]  ras_count
);

  localparam int unsigned       PTR_W      = $clog2(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);
  localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              addr_err_q, addr_err_d;
  logic              started_q, started_d;
  logic              ce_q, ce_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] ras_top;
  logic              misaligned;
  logic              push;
  logic              pop;

  always_comb begin
    pc_seq     = pc_q + STEP_INC;
    ras_top    = ras_q[ptr_q - PTR_W'(1)];
    misaligned = (branch_target & ALIGN_MASK) != '0;

    pc_d       = pc_q;
    epc_d      = epc_q;
    addr_err_d = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    // ce rises one edge after started, so the first enabled edge fetches RESET_VECTOR
    started_d  = 1'b1;
    ce_d       = started_q;

    if (ce_q) begin
      if (exc_flag) begin
        pc_d  = EXC_VECTOR;
        epc_d = pc_q;
      end else if (stall) begin
        pc_d = pc_q;
      end else if (branch_flag && misaligned) begin
        pc_d       = EXC_VECTOR;
        epc_d      = branch_target;
        addr_err_d = 1'b1;
      end else if (branch_flag) begin
        pc_d = branch_target;
        push = link_flag;
      end else if (ret_flag) begin
        if (cnt_q != '0) begin
          pc_d = ras_top;
          pop  = 1'b1;
        end else begin
          pc_d = branch_target & ~ALIGN_MASK;
        end
      end else begin
        pc_d = pc_seq;
      end
    end

    // Pointer always advances on push; when full the oldest slot is overwritten
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      addr_err_q <= 1'b0;
      started_q  <= 1'b0;
      ce_q       <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      addr_err_q <= addr_err_d;
      started_q  <= started_d;
      ce_q       <= ce_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  // Stack storage is not reset; entries are unreachable while the count is zero
  always_ff @(posedge clk) begin
    if (push) ras_q[ptr_q] <= pc_seq;
  end

  assign pc        = pc_q;
  assign ce        = ce_q;
  assign epc       = epc_q;
  assign addr_err  = addr_err_q;
  assign ras_count = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized flags checked against a
// queue-based reference model of fetch-address behaviour.
module tb_pc_gen;

  localparam int RAS_D = 4;

  logic        clk;
  logic        rst;
  logic        stall, exc_flag, branch_flag, link_flag, ret_flag;
  logic [31:0] branch_target;
  logic [31:0] pc, epc;
  logic        ce, addr_err;
  logic [2:0]  ras_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic        m_ce, m_aerr;
  logic [31:0] m_ras[$];
  int          m_edges;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .exc_flag(exc_flag),
    .branch_flag(branch_flag), .link_flag(link_flag), .ret_flag(ret_flag),
    .branch_target(branch_target), .pc(pc), .ce(ce), .epc(epc),
    .addr_err(addr_err), .ras_count(ras_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_ce = 1'b0; m_aerr = 1'b0;
    m_ras.delete();
    m_edges = 0;
  endtask

  task automatic model_edge();
    if (m_edges < 2) begin
      m_edges++;
      m_ce   = (m_edges == 2);
      m_aerr = 1'b0;
    end else begin
      m_aerr = 1'b0;
      if (exc_flag) begin
        m_epc = m_pc;
        m_pc  = 32'h20;
      end else if (stall) begin
        m_pc = m_pc;
      end else if (branch_flag && (branch_target % 4 != 0)) begin
        m_epc  = branch_target;
        m_pc   = 32'h20;
        m_aerr = 1'b1;
      end else if (branch_flag) begin
        if (link_flag) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > RAS_D) void'(m_ras.pop_front());
        end
        m_pc = branch_target;
      end else if (ret_flag) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else m_pc = branch_target - (branch_target % 4);
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input logic s, input logic e, input logic b, input logic l,
                      input logic r, input logic [31:0] t);
    @(negedge clk);
    stall = s; exc_flag = e; branch_flag = b; link_flag = l; ret_flag = r;
    branch_target = t;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    stall = 0; exc_flag = 0; branch_flag = 0; link_flag = 0; ret_flag = 0;
    branch_target = 32'h0;
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [5];
    logic        exp_ce [5];
    exp_pc = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
    exp_ce = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rst = 1'b0;
    stall = 0; exc_flag = 0; branch_flag = 0; link_flag = 0; ret_flag = 0;
    branch_target = 32'h0;
    model_reset();
    #2;
    n_checks++;
    if ({pc, ce, epc, addr_err, ras_count} !== {32'h0, 1'b0, 32'h0, 1'b0, 3'd0})
      $display("FAIL reset_state: got pc=%h ce=%b epc=%h aerr=%b cnt=%0d want all zero",
               pc, ce, epc, addr_err, ras_count);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) release_reset();
      else step(0, 0, 0, 0, 0, 32'h0);
      n_checks++;
      if (pc !== exp_pc[i] || ce !== exp_ce[i])
        $display("FAIL startup_edge%0d: got pc=%h ce=%b want pc=%h ce=%b",
                 i + 1, pc, ce, exp_pc[i], exp_ce[i]);
      else n_pass++;
    end
  endtask

  task automatic test_call_ret();
    step(0, 0, 1, 0, 0, 32'h100);
    step(0, 0, 1, 1, 0, 32'h400);
    n_checks++;
    if (pc !== 32'h400 || ras_count !== 3'd1)
      $display("FAIL call: got pc=%h cnt=%0d want pc=400 cnt=1", pc, ras_count);
    else n_pass++;
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 1, 32'h900);
    n_checks++;
    if (pc !== 32'h104 || ras_count !== 3'd0)
      $display("FAIL ret: got pc=%h cnt=%0d want pc=104 cnt=0", pc, ras_count);
    else n_pass++;
    step(0, 0, 0, 1, 0, 32'h700);
    n_checks++;
    if (pc !== 32'h108 || ras_count !== 3'd0)
      $display("FAIL link_alone: got pc=%h cnt=%0d want pc=108 cnt=0", pc, ras_count);
    else n_pass++;
    step(0, 0, 1, 1, 0, 32'h600);
    step(0, 0, 1, 0, 1, 32'h700);
    n_checks++;
    if (pc !== 32'h700 || ras_count !== 3'd1)
      $display("FAIL branch_and_ret: got pc=%h cnt=%0d want pc=700 cnt=1", pc, ras_count);
    else n_pass++;
    step(0, 0, 0, 0, 1, 32'h0);
    n_checks++;
    if (pc !== 32'h10C || ras_count !== 3'd0)
      $display("FAIL ret_after_both: got pc=%h cnt=%0d want pc=10c cnt=0", pc, ras_count);
    else n_pass++;
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_pc [5];
    logic [2:0]  exp_cnt [5];
    exp_pc  = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h800};
    exp_cnt = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    step(0, 0, 1, 0, 0, 32'h10);
    for (int i = 1; i <= 5; i++) step(0, 0, 1, 1, 0, 32'(16 * (i + 1)));
    n_checks++;
    if (pc !== 32'h60 || ras_count !== 3'd4)
      $display("FAIL ras_full: got pc=%h cnt=%0d want pc=60 cnt=4", pc, ras_count);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, 32'h803);
      n_checks++;
      if (pc !== exp_pc[i] || ras_count !== exp_cnt[i])
        $display("FAIL ras_ret%0d: got pc=%h cnt=%0d want pc=%h cnt=%0d",
                 i, pc, ras_count, exp_pc[i], exp_cnt[i]);
      else n_pass++;
    end
  endtask

  task automatic test_exception();
    step(0, 0, 1, 0, 0, 32'h1F0);
    step(0, 0, 1, 1, 0, 32'h200);
    step(1, 1, 1, 1, 0, 32'h400);
    n_checks++;
    if (pc !== 32'h20 || epc !== 32'h200 || ras_count !== 3'd1)
      $display("FAIL exception: got pc=%h epc=%h cnt=%0d want pc=20 epc=200 cnt=1",
               pc, epc, ras_count);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    step(0, 0, 1, 1, 0, 32'h402);
    n_checks++;
    if (pc !== 32'h20 || epc !== 32'h402 || addr_err !== 1'b1 || ras_count !== 3'd1)
      $display("FAIL misaligned: got pc=%h epc=%h aerr=%b cnt=%0d want pc=20 epc=402 aerr=1 cnt=1",
               pc, epc, addr_err, ras_count);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 1, 1, 32'h500);
      n_checks++;
      if (pc !== 32'h20 || addr_err !== 1'b0 || ras_count !== 3'd1 || epc !== 32'h402)
        $display("FAIL stall%0d: got pc=%h aerr=%b cnt=%0d epc=%h want pc=20 aerr=0 cnt=1 epc=402",
                 i, pc, addr_err, ras_count, epc);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset_wrap();
    step(0, 0, 1, 1, 0, 32'h300);
    step(0, 0, 1, 1, 0, 32'h340);
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({pc, ce, epc, addr_err, ras_count} !== {32'h0, 1'b0, 32'h0, 1'b0, 3'd0})
      $display("FAIL async_reset: got pc=%h ce=%b epc=%h aerr=%b cnt=%0d want all zero",
               pc, ce, epc, addr_err, ras_count);
    else n_pass++;
    release_reset();
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 1, 0, 0, 32'hFFFF_FFF8);
    step(0, 0, 0, 0, 0, 32'h0);
    n_checks++;
    if (pc !== 32'hFFFF_FFFC)
      $display("FAIL pre_wrap: got pc=%h want fffffffc", pc);
    else n_pass++;
    step(0, 0, 0, 0, 0, 32'h0);
    n_checks++;
    if (pc !== 32'h0 || addr_err !== 1'b0 || ce !== 1'b1)
      $display("FAIL wrap: got pc=%h aerr=%b ce=%b want pc=0 aerr=0 ce=1", pc, addr_err, ce);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] t;
    logic [68:0] exp_v, got_v;
    for (int i = 0; i < 400; i++) begin
      t = $urandom;
      if ($urandom_range(7) != 0) t[1:0] = 2'b00;
      step(($urandom_range(7) == 0), ($urandom_range(15) == 0), ($urandom_range(3) == 0),
           $urandom_range(1) == 1, ($urandom_range(4) == 0), t);
      exp_v = {m_pc, m_ce, m_epc, m_aerr, 3'(m_ras.size())};
      got_v = {pc, ce, epc, addr_err, ras_count};
      n_checks++;
      if (got_v !== exp_v)
        $display("FAIL random%0d: got pc=%h ce=%b epc=%h aerr=%b cnt=%0d want pc=%h ce=%b epc=%h aerr=%b cnt=%0d",
                 i, pc, ce, epc, addr_err, ras_count, m_pc, m_ce, m_epc, m_aerr, m_ras.size());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_call_ret();
    test_ras_overflow();
    test_exception();
    test_misaligned();
    test_async_reset_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
